// File: rtl/dense_result_collector_pkg.sv
// Shared dense-stream definitions: default geometry and collector FSM encoding.
package dense_result_collector_pkg;

    localparam int unsigned DENSE_DATA_WIDTH = 32;
    localparam int unsigned DENSE_BIAS       = 128;
    localparam int unsigned DENSE_IDX_WIDTH  = 7;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

endpackage

// File: rtl/dense_result_collector.sv
// Collects one neuron result per beat from the dense sequencer and presents
// the packed per-layer vector to the next layer over a valid/ready handshake.
module dense_result_collector
    import dense_result_collector_pkg::*;
#(
    parameter int unsigned BIAS       = DENSE_BIAS,
    parameter int unsigned DATA_WIDTH = DENSE_DATA_WIDTH,
    parameter int unsigned IDX_WIDTH  = DENSE_IDX_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_WIDTH-1:0]      in_data_i,
    input  logic                       in_last_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_WIDTH*BIAS-1:0] result_o,
    output logic [IDX_WIDTH-1:0]       cnt_o,
    output logic                       err_o
);

    // One spare bit so the count can reach BIAS even when BIAS == 2^IDX_WIDTH;
    // cnt_o carries the low IDX_WIDTH bits.
    localparam int unsigned CW = IDX_WIDTH + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(BIAS - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          err;
    logic          beat;
    logic          accept;
    logic          at_last;

    assign in_ready_o  = (state == ST_COLLECT);
    assign out_valid_o = (state == ST_FULL);
    assign cnt_o       = cnt[IDX_WIDTH-1:0];
    assign err_o       = err;

    assign beat    = in_valid_i && in_ready_o;
    assign accept  = beat && !start_i;
    assign at_last = (cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state <= ST_COLLECT;
                        cnt   <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (start_i) begin
                        cnt <= '0;
                        err <= 1'b1;
                    end else if (beat) begin
                        cnt <= cnt + 1'b1;
                        if (in_last_i != at_last)
                            err <= 1'b1;
                        if (at_last)
                            state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready_i) begin
                        if (start_i) begin
                            state <= ST_COLLECT;
                            cnt   <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < BIAS; k++) begin : g_slot
        logic [DATA_WIDTH-1:0] slot_q;
        logic                  we;

        assign we = accept && (cnt == CW'(k));

        always_ff @(posedge clk) begin
            if (rst_i)
                slot_q <= '0;
            else if (we)
                slot_q <= in_data_i;
        end

        assign result_o[k*DATA_WIDTH +: DATA_WIDTH] = slot_q;
    end

endmodule

// File: tb/tb_dense_result_collector.sv
// Directed bench for dense_result_collector with BIAS=4, DATA_WIDTH=8.
module tb_dense_result_collector;

    localparam int unsigned BIAS = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned IW   = 3;

    logic            clk = 1'b0;
    logic            rst_i = 1'b0;
    logic            start_i = 1'b0;
    logic            in_valid_i = 1'b0;
    logic            in_ready_o;
    logic [DW-1:0]   in_data_i = '0;
    logic            in_last_i = 1'b0;
    logic            out_valid_o;
    logic            out_ready_i = 1'b0;
    logic [DW*BIAS-1:0] result_o;
    logic [IW-1:0]   cnt_o;
    logic            err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dense_result_collector #(
        .BIAS       (BIAS),
        .DATA_WIDTH (DW),
        .IDX_WIDTH  (IW)
    ) dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .cnt_o       (cnt_o),
        .err_o       (err_o)
    );

    typedef struct {
        logic        rst;
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic        last;
        logic        oready;
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_res;
        logic        chk_cnt;
        logic [2:0]  e_cnt;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic start, logic valid, logic [7:0] data,
                                logic last, logic oready, logic e_ready, logic e_valid,
                                logic [31:0] e_res, logic chk_cnt, logic [2:0] e_cnt,
                                logic e_err);
        vec_t v;
        v.rst = rst; v.start = start; v.valid = valid; v.data = data;
        v.last = last; v.oready = oready; v.e_ready = e_ready; v.e_valid = e_valid;
        v.e_res = e_res; v.chk_cnt = chk_cnt; v.e_cnt = e_cnt; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic start, input logic valid,
                         input logic [7:0] data, input logic last, input logic oready);
        rst_i = rst; start_i = start; in_valid_i = valid;
        in_data_i = data; in_last_i = last; out_ready_i = oready;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input int idx, input logic e_ready, input logic e_valid,
                                 input logic [31:0] e_res, input logic chk_cnt,
                                 input logic [2:0] e_cnt, input logic e_err);
        chk("in_ready", idx, 32'(in_ready_o), 32'(e_ready));
        chk("out_valid", idx, 32'(out_valid_o), 32'(e_valid));
        chk("result", idx, result_o, e_res);
        chk("err", idx, 32'(err_o), 32'(e_err));
        if (chk_cnt)
            chk("cnt", idx, 32'(cnt_o), 32'(e_cnt));
    endtask

    initial begin
        //          rst st vld data  lst ordy | rdy val result        cc cnt err
        // reset, then idle with in_valid asserted
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0,  0, 0, 32'h00000000, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 8'hAA, 0, 0,  0, 0, 32'h00000000, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 8'hAA, 0, 0,  0, 0, 32'h00000000, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 8'hAA, 0, 0,  0, 0, 32'h00000000, 1, 0, 0));
        // back-to-back frame
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0,  1, 0, 32'h00000000, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 8'h11, 0, 0,  1, 0, 32'h00000011, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 8'h22, 0, 0,  1, 0, 32'h00002211, 1, 2, 0));
        vecs.push_back(mk(0, 0, 1, 8'h33, 0, 0,  1, 0, 32'h00332211, 1, 3, 0));
        vecs.push_back(mk(0, 0, 1, 8'h44, 1, 0,  0, 1, 32'h44332211, 1, 4, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1,  0, 0, 32'h44332211, 0, 0, 0));
        // gapped frame, downstream stalls for 5 cycles
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0,  1, 0, 32'h44332211, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 8'h11, 0, 0,  1, 0, 32'h44332211, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0,  1, 0, 32'h44332211, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 8'h22, 0, 0,  1, 0, 32'h44332211, 1, 2, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0,  1, 0, 32'h44332211, 1, 2, 0));
        vecs.push_back(mk(0, 0, 1, 8'h33, 0, 0,  1, 0, 32'h44332211, 1, 3, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0,  1, 0, 32'h44332211, 1, 3, 0));
        vecs.push_back(mk(0, 0, 1, 8'h44, 1, 0,  0, 1, 32'h44332211, 1, 4, 0));
        vecs.push_back(mk(0, 0, 1, 8'h99, 0, 0,  0, 1, 32'h44332211, 1, 4, 0));
        vecs.push_back(mk(0, 1, 1, 8'h99, 0, 0,  0, 1, 32'h44332211, 1, 4, 0));
        vecs.push_back(mk(0, 0, 1, 8'h99, 1, 0,  0, 1, 32'h44332211, 1, 4, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0,  0, 1, 32'h44332211, 1, 4, 0));
        vecs.push_back(mk(0, 0, 1, 8'h99, 0, 0,  0, 1, 32'h44332211, 1, 4, 0));
        // accept and restart together: no idle cycle
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 1,  1, 0, 32'h44332211, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 8'h01, 0, 0,  1, 0, 32'h44332201, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 8'h02, 0, 0,  1, 0, 32'h44330201, 1, 2, 0));
        vecs.push_back(mk(0, 0, 1, 8'h03, 0, 0,  1, 0, 32'h44030201, 1, 3, 0));
        vecs.push_back(mk(0, 0, 1, 8'h04, 1, 0,  0, 1, 32'h04030201, 1, 4, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1,  0, 0, 32'h04030201, 0, 0, 0));
        // abort after two beats; the beat with start is dropped
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0,  1, 0, 32'h04030201, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 8'h11, 0, 0,  1, 0, 32'h04030211, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 8'h22, 0, 0,  1, 0, 32'h04032211, 1, 2, 0));
        vecs.push_back(mk(0, 1, 1, 8'hEE, 0, 0,  1, 0, 32'h04032211, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 8'h55, 0, 0,  1, 0, 32'h04032255, 1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 8'h66, 0, 0,  1, 0, 32'h04036655, 1, 2, 1));
        vecs.push_back(mk(0, 0, 1, 8'h77, 0, 0,  1, 0, 32'h04776655, 1, 3, 1));
        vecs.push_back(mk(0, 0, 1, 8'h88, 1, 0,  0, 1, 32'h88776655, 1, 4, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1,  0, 0, 32'h88776655, 0, 0, 1));
        // reset clears err; early in_last flags err but frame still counts to 4
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0,  0, 0, 32'h00000000, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0,  1, 0, 32'h00000000, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 8'h11, 0, 0,  1, 0, 32'h00000011, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 8'h22, 1, 0,  1, 0, 32'h00002211, 1, 2, 1));
        vecs.push_back(mk(0, 0, 1, 8'h33, 0, 0,  1, 0, 32'h00332211, 1, 3, 1));
        vecs.push_back(mk(0, 0, 1, 8'h44, 1, 0,  0, 1, 32'h44332211, 1, 4, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1,  0, 0, 32'h44332211, 0, 0, 1));
        // reset in the middle of a frame
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0,  1, 0, 32'h44332211, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 8'h55, 0, 0,  1, 0, 32'h44332255, 1, 1, 1));
        vecs.push_back(mk(1, 0, 1, 8'h66, 0, 0,  0, 0, 32'h00000000, 1, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].valid, vecs[i].data,
                  vecs[i].last, vecs[i].oready);
            check_outputs(i, vecs[i].e_ready, vecs[i].e_valid, vecs[i].e_res,
                          vecs[i].chk_cnt, vecs[i].e_cnt, vecs[i].e_err);
        end

        // Final beat without in_last: err rises only on that beat.
        drive(1, 0, 0, 8'h00, 0, 0);
        drive(0, 1, 0, 8'h00, 0, 0);
        drive(0, 0, 1, 8'hA1, 0, 0);
        drive(0, 0, 1, 8'hA2, 0, 0);
        drive(0, 0, 1, 8'hA3, 0, 0);
        check_outputs(100, 1, 0, 32'h00A3A2A1, 1, 3, 0);
        drive(0, 0, 1, 8'hA4, 0, 0);
        begin
            int waited = 0;
            while (!out_valid_o && waited < 20) begin
                drive(0, 0, 0, 8'h00, 0, 0);
                waited++;
            end
            chk("out_valid_wait", 101, 32'(waited), 32'd0);
        end
        check_outputs(102, 0, 1, 32'hA4A3A2A1, 1, 4, 1);
        drive(0, 0, 0, 8'h00, 0, 1);
        check_outputs(103, 0, 0, 32'hA4A3A2A1, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
